// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin arbiter that grants NREQ requesters exclusive,
// fixed-latency access to an 8-lane byte-wide DRAM port.
module dram_arbiter #(
  parameter int NREQ     = 4,
  parameter int DRAM_LAT = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0]             req_rdwr,
  input  logic [NREQ-1:0][7:0]        req_en,
  input  logic [NREQ-1:0][7:0][63:0]  req_addr,
  input  logic [NREQ-1:0][7:0][7:0]   req_wdata,
  output logic [NREQ-1:0]             resp_valid,
  output logic [7:0][7:0]             resp_rdata,
  output logic [7:0]                  resp_lanes,
  output logic [7:0]                  dram_en,
  output logic                        dram_rdwr,
  output logic [7:0][7:0]             dram_data_in,
  output logic [7:0][63:0]            dram_addr,
  input  logic [7:0][7:0]             dram_data_out,
  input  logic [7:0]                  dram_valid
);

  localparam int         PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] LAST_CNT = 8'(DRAM_LAT - 2);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q;
  logic [PW-1:0]       owner_q;
  logic                rdwr_q;
  logic [7:0]          en_q;
  logic [7:0][63:0]    addr_q;
  logic [7:0][7:0]     wdata_q;
  logic [7:0]          cnt_q;
  logic [7:0][7:0]     rdata_q;

  logic [PW-1:0]       win;
  logic                grant;
  logic                dram_drive;
  logic                unused_dram_valid;

  // DRAM reply timing is fixed by DRAM_LAT, so the valid strobes carry no information
  always_comb unused_dram_valid = ^dram_valid;

  // Round-robin search starting at ptr_q for the first pending requester
  always_comb begin
    logic        found;
    int unsigned idx;
    found = 1'b0;
    idx   = 0;
    win   = ptr_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr_q) + i) % 32'(NREQ);
      if (!found && req_valid[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb grant = (state_q == S_IDLE) && (|req_valid) && !reset;

  // GRANT with a nonzero mask is already the first DRAM cycle, so BUSY lasts
  // DRAM_LAT-1 cycles and dram_en spans exactly DRAM_LAT cycles in total.
  always_comb dram_drive = (state_q == S_BUSY) || ((state_q == S_GRANT) && (en_q != '0));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (|req_valid) state_d = S_GRANT;
      S_GRANT: state_d = (en_q == '0) ? S_RESP : S_BUSY;
      S_BUSY:  if (cnt_q == LAST_CNT) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: grant, completion and DRAM request bus
  always_comb begin
    req_ready    = '0;
    resp_valid   = '0;
    resp_lanes   = '0;
    dram_en      = '0;
    dram_rdwr    = 1'b0;
    dram_addr    = '0;
    dram_data_in = '0;
    if (grant) req_ready = NREQ'(1) << win;
    if (state_q == S_RESP) begin
      resp_valid = NREQ'(1) << owner_q;
      resp_lanes = en_q;
    end
    if (dram_drive) begin
      dram_en      = en_q;
      dram_rdwr    = rdwr_q;
      dram_addr    = addr_q;
      dram_data_in = wdata_q;
    end
  end

  always_comb resp_rdata = rdata_q;

  // Transaction capture, pointer advance, wait counter and read-data register
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      owner_q <= '0;
      rdwr_q  <= 1'b0;
      en_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (grant) begin
        owner_q <= win;
        ptr_q   <= PW'((32'(win) + 1) % 32'(NREQ));
        rdwr_q  <= req_rdwr[win];
        en_q    <= req_en[win];
        addr_q  <= req_addr[win];
        wdata_q <= req_wdata[win];
        rdata_q <= '0;
      end
      if (state_q == S_GRANT) cnt_q <= '0;
      if (state_q == S_BUSY) begin
        cnt_q <= cnt_q + 8'd1;
        if ((cnt_q == LAST_CNT) && rdwr_q) begin
          for (int unsigned l = 0; l < 8; l++) begin
            rdata_q[l] <= en_q[l] ? dram_data_out[l] : 8'h00;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: self-checking bench with a behavioural DRAM and a
// reference memory / round-robin model for dram_arbiter.
module tb_dram_arbiter;
  localparam int NREQ     = 4;
  localparam int DRAM_LAT = 24;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0]             req_rdwr;
  logic [NREQ-1:0][7:0]        req_en;
  logic [NREQ-1:0][7:0][63:0]  req_addr;
  logic [NREQ-1:0][7:0][7:0]   req_wdata;
  logic [NREQ-1:0]             resp_valid;
  logic [7:0][7:0]             resp_rdata;
  logic [7:0]                  resp_lanes;
  logic [7:0]                  dram_en;
  logic                        dram_rdwr;
  logic [7:0][7:0]             dram_data_in;
  logic [7:0][63:0]            dram_addr;
  logic [7:0][7:0]             dram_data_out;
  logic [7:0]                  dram_valid;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] dmem    [logic [63:0]];
  logic [7:0] ref_mem [logic [63:0]];

  dram_arbiter #(.NREQ(NREQ), .DRAM_LAT(DRAM_LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rdwr(req_rdwr),
    .req_en(req_en), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_lanes(resp_lanes),
    .dram_en(dram_en), .dram_rdwr(dram_rdwr), .dram_data_in(dram_data_in),
    .dram_addr(dram_addr), .dram_data_out(dram_data_out), .dram_valid(dram_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural DRAM: writes land, reads return stored bytes, idle lanes carry junk
  always @(negedge clk) begin
    for (int l = 0; l < 8; l++) begin
      if (dram_en[l] && !dram_rdwr) dmem[dram_addr[l]] = dram_data_in[l];
      if (dram_en[l] && dram_rdwr)
        dram_data_out[l] = dmem.exists(dram_addr[l]) ? dmem[dram_addr[l]] : 8'h00;
      else
        dram_data_out[l] = 8'($urandom);
    end
    dram_valid = dram_en;
  end

  function automatic logic [63:0] exp_rdata(input logic rd, input logic [7:0] en,
                                            input logic [7:0][63:0] a);
    logic [7:0][7:0] d;
    d = '0;
    if (rd)
      for (int l = 0; l < 8; l++)
        if (en[l]) d[l] = ref_mem.exists(a[l]) ? ref_mem[a[l]] : 8'h00;
    return d;
  endfunction

  task automatic commit_write(input logic [7:0] en, input logic [7:0][63:0] a,
                              input logic [7:0][7:0] wd);
    for (int l = 0; l < 8; l++) if (en[l]) ref_mem[a[l]] = wd[l];
  endtask

  function automatic int rr_pick(input int p, input logic [NREQ-1:0] m);
    for (int k = 0; k < NREQ; k++) if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic scramble_inputs();
    for (int k = 0; k < NREQ; k++) begin
      req_rdwr[k] = 1'($urandom);
      req_en[k]   = 8'($urandom);
      for (int l = 0; l < 8; l++) begin
        req_addr[k][l]  = {32'($urandom), 32'($urandom)};
        req_wdata[k][l] = 8'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue one transaction from requester r alone and observe it to completion
  task automatic run_txn(input int r, input logic rd, input logic [7:0] en,
                         input logic [7:0][63:0] a, input logic [7:0][7:0] wd,
                         output int gcyc, output int rcyc, output int den_cnt,
                         output int den_first, output bit bad, output logic [63:0] rdata,
                         output logic [7:0] lanes, output logic [NREQ-1:0] rv, output bit tout);
    gcyc = -1; rcyc = -1; den_cnt = 0; den_first = -1; bad = 1'b0;
    rdata = '0; lanes = '0; rv = '0; tout = 1'b0;
    @(negedge clk);
    scramble_inputs();
    req_rdwr[r] = rd; req_en[r] = en; req_addr[r] = a; req_wdata[r] = wd;
    req_valid = '0;
    req_valid[r] = 1'b1;
    #1;
    for (int i = 0; i < 200; i++) begin
      if (req_ready[r]) begin gcyc = cyc; break; end
      @(negedge clk); #1;
    end
    if (gcyc < 0) begin tout = 1'b1; req_valid = '0; return; end
    @(posedge clk); #1;
    req_valid = '0;
    scramble_inputs();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (req_ready != '0) bad = 1'b1;
      if (dram_en != '0) begin
        den_cnt++;
        if (den_first < 0) den_first = cyc;
        if (dram_en !== en || dram_rdwr !== rd || dram_addr !== a || dram_data_in !== wd) bad = 1'b1;
      end else if (dram_rdwr !== 1'b0 || dram_addr !== '0 || dram_data_in !== '0) begin
        bad = 1'b1;
      end
      if (resp_valid != '0) begin
        rcyc = cyc; rdata = resp_rdata; lanes = resp_lanes; rv = resp_valid;
        break;
      end
    end
    if (rcyc < 0) tout = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '1;
    scramble_inputs();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_ready got=%h want=0", req_ready); end
    checks++; if (resp_valid !== '0) begin failures++; $display("FAIL reset_resp_valid got=%h want=0", resp_valid); end
    checks++; if (resp_rdata !== '0 || resp_lanes !== '0) begin failures++;
      $display("FAIL reset_resp got=%h/%h want=0/0", resp_rdata, resp_lanes); end
    checks++; if (dram_en !== '0 || dram_rdwr !== 1'b0 || dram_addr !== '0 || dram_data_in !== '0) begin
      failures++; $display("FAIL reset_dram en=%h rdwr=%b want all zero", dram_en, dram_rdwr); end
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    int g, rc, dc, df; bit bad, to; logic [63:0] rd; logic [7:0] ln; logic [NREQ-1:0] rv;
    logic [7:0][63:0] a; logic [7:0][7:0] wd;
    a = '0; wd = '0; a[0] = 64'd5; wd[0] = 8'hA5;
    run_txn(0, 1'b0, 8'h01, a, wd, g, rc, dc, df, bad, rd, ln, rv, to);
    commit_write(8'h01, a, wd);
    checks++; if (to || rc != g + 25) begin failures++; $display("FAIL wr_latency got=%0d want=%0d", rc - g, 25); end
    checks++; if (rv !== 4'b0001 || rd !== '0) begin failures++; $display("FAIL wr_resp rv=%b rdata=%h want 0001/0", rv, rd); end
    checks++; if (dc != DRAM_LAT || df != g + 1 || bad) begin failures++;
      $display("FAIL wr_dram cnt=%0d first=+%0d bad=%0d want %0d/+1/0", dc, df - g, bad, DRAM_LAT); end
    wd = '0;
    run_txn(0, 1'b1, 8'h01, a, wd, g, rc, dc, df, bad, rd, ln, rv, to);
    checks++; if (to || rc != g + 25) begin failures++; $display("FAIL rd_latency got=%0d want=25", rc - g); end
    checks++; if (rd !== 64'h00000000000000A5 || ln !== 8'h01) begin failures++;
      $display("FAIL rd_data got=%h lanes=%h want=a5/01", rd, ln); end
  endtask

  task automatic test_zero_en();
    int g, rc, dc, df; bit bad, to; logic [63:0] rd; logic [7:0] ln; logic [NREQ-1:0] rv;
    run_txn(2, 1'b1, 8'h00, '1, '1, g, rc, dc, df, bad, rd, ln, rv, to);
    checks++; if (to || rc != g + 2) begin failures++; $display("FAIL zero_en_latency got=%0d want=2", rc - g); end
    checks++; if (rv !== 4'b0100 || rd !== '0 || ln !== '0) begin failures++;
      $display("FAIL zero_en_resp rv=%b rdata=%h lanes=%h want 0100/0/0", rv, rd, ln); end
    checks++; if (dc != 0 || bad) begin failures++; $display("FAIL zero_en_dram cnt=%0d bad=%0d want 0/0", dc, bad); end
  endtask

  task automatic test_full_read();
    int g, rc, dc, df; bit bad, to; logic [63:0] rd; logic [7:0] ln; logic [NREQ-1:0] rv;
    logic [7:0][63:0] a; logic [7:0][7:0] wd;
    for (int l = 0; l < 8; l++) begin a[l] = 64'(l); wd[l] = 8'(8'h10 + l); end
    run_txn(1, 1'b0, 8'hFF, a, wd, g, rc, dc, df, bad, rd, ln, rv, to);
    commit_write(8'hFF, a, wd);
    checks++; if (to || bad || ln !== 8'hFF) begin failures++; $display("FAIL full_wr to=%0d bad=%0d lanes=%h", to, bad, ln); end
    run_txn(1, 1'b1, 8'hFF, a, '0, g, rc, dc, df, bad, rd, ln, rv, to);
    checks++; if (to || rd !== 64'h1716151413121110 || ln !== 8'hFF) begin failures++;
      $display("FAIL full_rd got=%h lanes=%h want=1716151413121110/ff", rd, ln); end
  endtask

  task automatic test_rr_all();
    int gc[$]; logic [NREQ-1:0] gr[$];
    @(negedge clk);
    reset = 1'b1;
    scramble_inputs();
    req_rdwr = '1;
    for (int k = 0; k < NREQ; k++) req_en[k] = 8'h01;
    req_valid = '1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 5 * (DRAM_LAT + 2) + 20 && gc.size() < 5; i++) begin
      if (req_ready != '0) begin gc.push_back(cyc); gr.push_back(req_ready); end
      @(negedge clk); #1;
    end
    req_valid = '0;
    checks++; if (gc.size() != 5) begin failures++; $display("FAIL rr_all_count got=%0d want=5", gc.size()); end
    for (int k = 0; k < gc.size(); k++) begin
      checks++; if (gr[k] !== NREQ'(1) << (k % NREQ)) begin failures++;
        $display("FAIL rr_all_order[%0d] got=%b want=%b", k, gr[k], NREQ'(1) << (k % NREQ)); end
      if (k > 0) begin
        checks++; if (gc[k] - gc[k-1] != DRAM_LAT + 2) begin failures++;
          $display("FAIL rr_all_spacing[%0d] got=%0d want=%0d", k, gc[k] - gc[k-1], DRAM_LAT + 2); end
      end
    end
    repeat (DRAM_LAT + 6) @(negedge clk);
  endtask

  task automatic test_reset_mid_busy();
    int g; bit saw1;
    do_reset();
    @(negedge clk);
    scramble_inputs();
    req_rdwr[1] = 1'b1; req_en[1] = 8'hFF;
    req_rdwr[0] = 1'b1; req_en[0] = 8'h00;
    req_valid = 4'b0010;
    #1;
    g = -1;
    for (int i = 0; i < 50; i++) begin
      if (req_ready[1]) begin g = cyc; break; end
      @(negedge clk); #1;
    end
    checks++; if (g < 0) begin failures++; $display("FAIL abort_grant timeout"); return; end
    @(posedge clk); #1;
    req_valid = 4'b0111;
    saw1 = 1'b0;
    for (int i = 0; i < 40 && cyc < g + 12; i++) begin
      if (resp_valid[1]) saw1 = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (dram_en !== 8'hFF) begin failures++; $display("FAIL abort_busy dram_en got=%h want=ff", dram_en); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    checks++; if (dram_en !== '0 || resp_valid !== '0) begin failures++;
      $display("FAIL abort_after dram_en=%h resp_valid=%b want 0/0", dram_en, resp_valid); end
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL abort_next_grant got=%b want=0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    for (int i = 0; i < 45; i++) begin
      if (resp_valid[1]) saw1 = 1'b1;
      @(negedge clk); #1;
    end
    checks++; if (saw1) begin failures++; $display("FAIL abort_no_resp got resp_valid[1]=1 want never"); end
  endtask

  task automatic test_wrap();
    int g, rc, dc, df; bit bad, to; logic [63:0] rd; logic [7:0] ln; logic [NREQ-1:0] rv;
    do_reset();
    run_txn(0, 1'b1, 8'h00, '0, '0, g, rc, dc, df, bad, rd, ln, rv, to);
    run_txn(3, 1'b1, 8'h00, '0, '0, g, rc, dc, df, bad, rd, ln, rv, to);
    checks++; if (to || rv !== 4'b1000) begin failures++; $display("FAIL wrap_grant3 rv=%b want=1000", rv); end
    repeat (2) @(negedge clk);
    scramble_inputs();
    req_valid = 4'b1011;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL wrap_ptr0 got=%b want=0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (DRAM_LAT + 4) @(negedge clk);
  endtask

  task automatic test_rr_random();
    int p; int w; bit got;
    logic [NREQ-1:0] m;
    do_reset();
    p = 0;
    for (int n = 0; n < 12; n++) begin
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      w = rr_pick(p, m);
      @(negedge clk);
      scramble_inputs();
      req_en = '0;
      req_valid = m;
      #1;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (req_ready != '0) begin got = 1'b1; break; end
        @(negedge clk); #1;
      end
      checks++; if (!got || req_ready !== NREQ'(1) << w) begin failures++;
        $display("FAIL rr_rand[%0d] mask=%b got=%b want=%b", n, m, req_ready, NREQ'(1) << w); end
      @(posedge clk); #1;
      req_valid = '0;
      p = (w + 1) % NREQ;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_random();
    int g, rc, dc, df; bit bad, to; logic [63:0] rd; logic [7:0] ln; logic [NREQ-1:0] rv;
    logic [7:0][63:0] a; logic [7:0][7:0] wd; logic [7:0] en; logic rdw; int r;
    logic [63:0] exp;
    for (int n = 0; n < 16; n++) begin
      r   = $urandom_range(0, NREQ - 1);
      rdw = 1'($urandom);
      en  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      for (int l = 0; l < 8; l++) begin
        a[l]  = 64'($urandom_range(0, 3) * 8 + l);
        wd[l] = 8'($urandom);
      end
      exp = exp_rdata(rdw, en, a);
      run_txn(r, rdw, en, a, wd, g, rc, dc, df, bad, rd, ln, rv, to);
      if (!rdw) commit_write(en, a, wd);
      checks++; if (to || rc != g + ((en == 0) ? 2 : DRAM_LAT + 1)) begin failures++;
        $display("FAIL rand_latency[%0d] got=%0d en=%h", n, rc - g, en); end
      checks++; if (rv !== NREQ'(1) << r || ln !== en) begin failures++;
        $display("FAIL rand_resp[%0d] rv=%b lanes=%h want %b/%h", n, rv, ln, NREQ'(1) << r, en); end
      checks++; if (rd !== exp) begin failures++; $display("FAIL rand_rdata[%0d] got=%h want=%h", n, rd, exp); end
      checks++; if (bad || dc != ((en == 0) ? 0 : DRAM_LAT)) begin failures++;
        $display("FAIL rand_dram[%0d] cnt=%0d bad=%0d", n, dc, bad); end
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_rdwr = '0; req_en = '0; req_addr = '0; req_wdata = '0;
    dram_data_out = '0; dram_valid = '0;
    test_reset();
    test_write_read();
    test_zero_en();
    test_full_read();
    test_rr_all();
    test_reset_mid_busy();
    test_wrap();
    test_rr_random();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout sim time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requester ports, range 2..8.
REQ-002 Parameter DRAM_LAT, default 24: cycles dram_en is held per transaction; the DRAM wait count plus capture and reply cycles, at least 22.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  NREQ  requester i has a pending transaction.
REQ-006 req_ready  out  NREQ  one-hot grant; a transfer is accepted when req_valid[i] & req_ready[i].
REQ-007 req_rdwr  in  NREQ  per requester: 1 = read, 0 = write.
REQ-008 req_en  in  NREQ x 8  lane-enable mask per requester.
REQ-009 req_addr  in  NREQ x 8 x 64  per-lane address per requester.
REQ-010 req_wdata  in  NREQ x 8 x 8  per-lane write byte per requester.
REQ-011 resp_valid  out  NREQ  one-cycle completion pulse to the granted requester.
REQ-012 resp_rdata  out  8 x 8  read bytes shared by all requesters, qualified by resp_valid.
REQ-013 resp_lanes  out  8  lane mask of the completed transaction.
REQ-014 dram_en, dram_rdwr, dram_data_in, dram_addr  out  8, 1, 8x8, 8x64  DRAM request bus.
REQ-015 dram_data_out, dram_valid  in  8x8, 8  DRAM reply bus; dram_valid is ignored for timing.

Function
REQ-016 The state machine SHALL have four states: IDLE, GRANT, BUSY and RESP.
REQ-017 IDLE: if any req_valid is set, the block SHALL assert req_ready for the round-robin winner in the same cycle and go to GRANT; otherwise it SHALL stay in IDLE.
REQ-018 Round-robin: the search SHALL start at index ptr and the winner SHALL be the first set req_valid, wrapping from NREQ-1 to 0; ptr SHALL become winner+1 (mod NREQ) on each grant.
REQ-019 On grant, rdwr, en, addr and wdata of the winner SHALL be latched; requester inputs SHALL then be ignored until the next IDLE.
REQ-020 If the latched en is 0, the block SHALL go from GRANT straight to RESP with no DRAM activity, and resp_rdata SHALL be 0.
REQ-021 GRANT (en nonzero) SHALL go to BUSY with the counter cleared.
REQ-022 BUSY: dram_en, dram_rdwr, dram_addr and dram_data_in SHALL be driven from the latched values for exactly DRAM_LAT consecutive cycles, held stable throughout.
REQ-023 In the last BUSY cycle, for reads, dram_data_out lanes in en SHALL be registered into resp_rdata and lanes not in en SHALL be 0; then the block SHALL go to RESP.
REQ-024 For writes, resp_rdata SHALL be 0.
REQ-025 RESP: resp_valid[owner] SHALL be 1 for one cycle and resp_lanes SHALL equal the latched en; the block SHALL then go to IDLE.
REQ-026 Outside BUSY, dram_en SHALL be 0 and the other DRAM outputs SHALL be 0; this guarantees at least 2 idle DRAM cycles between transactions.
REQ-027 At most one req_ready bit and at most one resp_valid bit SHALL be set per cycle, and req_ready SHALL be 0 outside IDLE.
REQ-028 Latency (en nonzero): a grant in cycle T SHALL put dram_en high in T+1..T+DRAM_LAT and resp_valid in T+DRAM_LAT+1; the next grant is possible at T+DRAM_LAT+2.
REQ-029 The counter SHALL be 8-bit and saturate-free, and DRAM_LAT SHALL be at most 255.

Reset
REQ-030 On reset: state=IDLE, ptr=0, counter=0, req_ready=0, resp_valid=0, resp_rdata=0, resp_lanes=0, all DRAM outputs 0.
REQ-031 Reset mid-BUSY SHALL abort the transaction with no resp_valid; the aborted requester must reissue.
REQ-032 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-033 Requester 0 writes en=0x01, addr 5, data 0xA5, then reads en=0x01, addr 5 -> write resp_valid[0] at T+25; read resp_rdata[0]=0xA5, resp_lanes=0x01.
REQ-034 All 4 req_valid held high from reset -> grants in order 0,1,2,3,0, with spacing DRAM_LAT+2=26 cycles.
REQ-035 Requester 2 reads with en=0x00 -> resp_valid[2] 2 cycles after grant, resp_rdata=0, dram_en never asserted.
REQ-036 Read, en=0xFF, addresses 0..7 preloaded with 0x10..0x17 -> resp_rdata lanes 0x10..0x17, resp_lanes=0xFF.
REQ-037 Reset asserted at BUSY count 10 -> no resp_valid, dram_en=0 next cycle, next grant goes to requester 0.
REQ-038 Only requester 3 valid after ptr=1 -> requester 3 is granted through the wrap, and ptr becomes 0.
